// File: rtl/alu_pkg.sv
// Shared types for the ALU arbiter: op codes, FSM states, latency counter width.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package alu_pkg;

   localparam int LAT_W = 4;

   typedef enum logic [2:0] {
      ADD = 3'd0,
      SUB,
      AND,
      OR,
      XOR,
      SLL,
      SRA
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } arb_state_t;

   // Operand bundle as it is presented to the ALU.
   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  op;
      logic        is_fp;
   } alu_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the requester that lost the last grant wins a tie.
// Latency: grant is combinational from req; priority flips on the edge where update is high.
// Backpressure: none; the caller strobes update only when the grant is actually taken.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       update,
   output logic [1:0] grant
);

   logic prio;  // 1: requester 1 wins a tie

   // A lone requester always wins; on a tie the priority holder wins.
   always_comb begin
      grant = req;
      if (req == 2'b11) begin
         grant = prio ? 2'b10 : 2'b01;
      end
   end

   // Hand priority to the requester that was not granted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prio <= 1'b0;
      end else if (update && (|grant)) begin
         prio <= grant[0];
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between the integer and FP issue paths, round-robin.
// Latency: result sampled L cycles after accept (L = INT_LATENCY or FP_LATENCY); rsp_valid follows.
// Backpressure: no request accepted while busy; response held until the owner's rsp_ready.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int FP_LATENCY  = 3,
   parameter int INT_LATENCY = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [1:0][31:0] req_a,
   input  logic [1:0][31:0] req_b,
   input  logic [1:0][2:0]  req_op,
   input  logic [1:0]       req_is_fp,
   output logic [31:0]      alu_a,
   output logic [31:0]      alu_b,
   output logic [2:0]       alu_op,
   output logic             alu_is_fp,
   input  logic [31:0]      alu_result,
   output logic [1:0]       rsp_valid,
   input  logic [1:0]       rsp_ready,
   output logic [31:0]      rsp_result,
   output logic             busy
);

   // Counter loads are latency-1 so that count 0 lands on the sampling edge.
   localparam logic [LAT_W-1:0] FP_LOAD  = LAT_W'(FP_LATENCY - 1);
   localparam logic [LAT_W-1:0] INT_LOAD = LAT_W'(INT_LATENCY - 1);

   arb_state_t       state, state_nxt;
   logic [1:0]       grant;
   logic             accept;
   logic             owner;   // requester that owns the in-flight op
   logic [LAT_W-1:0] cnt;
   alu_req_t         sel;

   rr_arb2 u_rr_arb2 (
      .clk    (clk),
      .rst    (rst),
      .req    (req_valid),
      .update (accept),
      .grant  (grant)
   );

   // Payload of the granted requester.
   always_comb begin
      if (grant[1]) begin
         sel = {req_a[1], req_b[1], req_op[1], req_is_fp[1]};
      end else begin
         sel = {req_a[0], req_b[0], req_op[0], req_is_fp[0]};
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and handshake outputs; ready is masked while reset is held.
   always_comb begin
      state_nxt = state;
      req_ready = 2'b00;
      rsp_valid = 2'b00;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if ((|req_valid) && !rst) begin
               accept    = 1'b1;
               req_ready = grant;
               state_nxt = EXEC;
            end
         end
         EXEC: begin
            if (cnt == '0) begin
               state_nxt = RESP;
            end
         end
         RESP: begin
            rsp_valid[owner] = 1'b1;
            if (rsp_ready[owner]) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   // Operand capture on accept, latency countdown, result capture at count 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_a      <= '0;
         alu_b      <= '0;
         alu_op     <= '0;
         alu_is_fp  <= 1'b0;
         owner      <= 1'b0;
         cnt        <= '0;
         rsp_result <= '0;
      end else if (accept) begin
         alu_a     <= sel.a;
         alu_b     <= sel.b;
         alu_op    <= sel.op;
         alu_is_fp <= sel.is_fp;
         owner     <= grant[1];
         cnt       <= sel.is_fp ? FP_LOAD : INT_LOAD;
      end else if (state == EXEC) begin
         if (cnt == '0) begin
            rsp_result <= alu_result;
         end else begin
            cnt <= cnt - LAT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural ALU and a response scoreboard.
// Latency: inputs driven on falling edges, outputs sampled shortly before rising edges.
// Backpressure: exercises response stalls and a competing requester while busy.
module tb_alu_arbiter;
   import alu_pkg::*;

   localparam int FP_LAT  = 3;
   localparam int INT_LAT = 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [1:0][31:0] req_a;
   logic [1:0][31:0] req_b;
   logic [1:0][2:0]  req_op;
   logic [1:0]       req_is_fp;
   logic [31:0]      alu_a;
   logic [31:0]      alu_b;
   logic [2:0]       alu_op;
   logic             alu_is_fp;
   logic [31:0]      alu_result;
   logic [1:0]       rsp_valid;
   logic [1:0]       rsp_ready;
   logic [31:0]      rsp_result;
   logic             busy;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      int          owner;
      logic [31:0] res;
      int          lat;
      int          t;
   } exp_t;

   exp_t        exp_q[$];
   int          grant_log[$];
   int          cyc      = 0;
   int          n_accept = 0;
   logic        prio_m   = 1'b0;
   logic        rsp_seen = 1'b0;
   logic        just_acc = 1'b0;
   logic [67:0] held     = '0;
   logic [1:0]  exp_g;

   alu_arbiter #(
      .FP_LATENCY  (FP_LAT),
      .INT_LATENCY (INT_LAT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_op     (req_op),
      .req_is_fp  (req_is_fp),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_is_fp  (alu_is_fp),
      .alu_result (alu_result),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Behavioural ALU; the FP path is a stand-in that just differs from integer ADD.
   function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] op, input logic fp);
      logic [31:0] r;
      if (fp) begin
         r = (a + b) ^ 32'h8000_0000;
      end else begin
         case (op)
            3'd0:    r = a + b;
            3'd1:    r = a - b;
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd4:    r = a ^ b;
            3'd5:    r = a << b[4:0];
            3'd6:    r = 32'($signed(a) >>> b[4:0]);
            default: r = 32'h0;
         endcase
      end
      return r;
   endfunction

   assign alu_result = alu_model(alu_a, alu_b, alu_op, alu_is_fp);

   task automatic check(input string tag, input logic [71:0] act, input logic [71:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   // Scoreboard: grant order, operand hold, response latency/owner/result.
   always @(negedge clk) begin
      #3;
      cyc++;
      if (rst) begin
         check("rst_rsp_valid", 72'(rsp_valid), 72'(0));
         check("rst_busy", 72'(busy), 72'(0));
         exp_q.delete();
         prio_m   = 1'b0;
         rsp_seen = 1'b0;
         just_acc = 1'b0;
      end else begin
         if (just_acc) check("busy_after_acc", 72'(busy), 72'(1));
         just_acc = 1'b0;
         if (busy) begin
            check("alu_hold", 72'({alu_a, alu_b, alu_op, alu_is_fp}), 72'(held));
            if (|req_valid) check("ready_while_busy", 72'(req_ready), 72'(0));
         end else if (|req_valid) begin
            exp_g = (req_valid == 2'b11) ? (prio_m ? 2'b10 : 2'b01) : req_valid;
            check("grant", 72'(req_ready), 72'(exp_g));
            for (int i = 0; i < 2; i++) begin
               if (req_valid[i] && req_ready[i]) begin
                  exp_q.push_back('{owner: i,
                                    res:   alu_model(req_a[i], req_b[i], req_op[i], req_is_fp[i]),
                                    lat:   req_is_fp[i] ? FP_LAT : INT_LAT,
                                    t:     cyc});
                  held = {req_a[i], req_b[i], req_op[i], req_is_fp[i]};
                  grant_log.push_back(i);
                  n_accept++;
                  prio_m   = (i == 0);
                  just_acc = 1'b1;
               end
            end
         end
         if (|rsp_valid) begin
            if (exp_q.size() == 0) begin
               check("rsp_unexpected", 72'(rsp_valid), 72'(0));
            end else begin
               if (!rsp_seen) begin
                  // Sample cyc precedes edge (accept edge + cyc - t); the edge just passed raised rsp_valid.
                  check("rsp_latency", 72'(cyc - 1 - exp_q[0].t), 72'(exp_q[0].lat));
                  check("rsp_result", 72'(rsp_result), 72'(exp_q[0].res));
                  rsp_seen = 1'b1;
               end
               check("rsp_owner", 72'(rsp_valid), 72'(2'b01 << exp_q[0].owner));
               if (rsp_valid[exp_q[0].owner] && rsp_ready[exp_q[0].owner]) begin
                  void'(exp_q.pop_front());
                  rsp_seen = 1'b0;
               end
            end
         end
      end
   end

   // Called on a falling edge; returns on the falling edge after the accept edge.
   task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic fp);
      int n = 0;
      req_a[i]     = a;
      req_b[i]     = b;
      req_op[i]    = op;
      req_is_fp[i] = fp;
      req_valid[i] = 1'b1;
      #4;
      while (!req_ready[i] && n < 50) begin
         @(negedge clk);
         #4;
         n++;
      end
      check("accept", 72'(req_ready[i]), 72'(1));
      @(negedge clk);
      req_valid[i] = 1'b0;
   endtask

   // Called on a falling edge; waits for the scoreboard to drain and the block to go idle.
   task automatic wait_done();
      int n = 0;
      #4;
      while ((exp_q.size() != 0 || busy) && n < 100) begin
         @(negedge clk);
         #4;
         n++;
      end
      check("drain", 72'((exp_q.size() != 0) || busy), 72'(0));
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      int target;
      int start;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      req_op    = '0;
      req_is_fp = '0;
      rsp_ready = 2'b11;

      // Reset values
      #3;
      check("reset_req_ready", 72'(req_ready), 72'(0));
      check("reset_rsp_valid", 72'(rsp_valid), 72'(0));
      check("reset_busy", 72'(busy), 72'(0));
      check("reset_alu", 72'({alu_a, alu_b, alu_op, alu_is_fp}), 72'(0));
      check("reset_rsp_result", 72'(rsp_result), 72'(0));
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Single integer ADD 5+7 from requester 0
      issue(0, 32'd5, 32'd7, 3'd0, 1'b0);
      #4;
      check("add_alu_a", 72'(alu_a), 72'(5));
      check("add_alu_b", 72'(alu_b), 72'(7));
      @(negedge clk);
      #4;
      check("add_rsp_valid", 72'(rsp_valid), 72'(2'b01));
      check("add_rsp_result", 72'(rsp_result), 72'(12));
      @(negedge clk);
      wait_done();

      // FP op from requester 1
      issue(1, 32'h4000_0000, 32'h0000_1234, 3'd0, 1'b1);
      wait_done();

      // Integer op 7 with all-ones operand returns zero
      issue(0, 32'hFFFF_FFFF, 32'h0000_0001, 3'b111, 1'b0);
      @(negedge clk);
      #4;
      check("op7_rsp_valid", 72'(rsp_valid), 72'(2'b01));
      check("op7_rsp_result", 72'(rsp_result), 72'(0));
      @(negedge clk);
      wait_done();

      // Response backpressure with a competing requester; non-owner ready is ignored
      rsp_ready = 2'b10;
      issue(0, 32'd100, 32'd30, 3'd1, 1'b0);
      req_a[1]     = 32'd9;
      req_b[1]     = 32'd3;
      req_op[1]    = 3'd5;
      req_is_fp[1] = 1'b0;
      req_valid[1] = 1'b1;
      n = 0;
      #4;
      while (!rsp_valid[0] && n < 50) begin
         @(negedge clk);
         #4;
         n++;
      end
      check("bp_rsp_up", 72'(rsp_valid), 72'(2'b01));
      repeat (5) begin
         @(negedge clk);
         #4;
         check("bp_rsp_valid", 72'(rsp_valid), 72'(2'b01));
         check("bp_rsp_result", 72'(rsp_result), 72'(70));
         check("bp_busy", 72'(busy), 72'(1));
      end
      @(negedge clk);
      rsp_ready = 2'b11;
      @(negedge clk);
      #4;
      check("bp_idle_after", 72'(busy), 72'(0));
      check("bp_req1_ready", 72'(req_ready), 72'(2'b10));
      @(negedge clk);
      req_valid[1] = 1'b0;
      wait_done();

      // Reset during the second EXEC cycle of an FP op
      issue(1, 32'h10, 32'h20, 3'd0, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst_req_ready", 72'(req_ready), 72'(0));
      check("mid_rst_rsp_valid", 72'(rsp_valid), 72'(0));
      check("mid_rst_busy", 72'(busy), 72'(0));
      check("mid_rst_alu", 72'({alu_a, alu_b, alu_op, alu_is_fp}), 72'(0));
      check("mid_rst_rsp_result", 72'(rsp_result), 72'(0));
      @(negedge clk);
      rst = 1'b0;
      #4;
      check("post_rst_busy", 72'(busy), 72'(0));
      repeat (FP_LAT + 2) begin
         @(negedge clk);
         #4;
         check("post_rst_no_rsp", 72'(rsp_valid), 72'(0));
      end
      @(negedge clk);

      // Both requesters held valid after reset: strict alternation starting at 0
      req_a     = {32'd3, 32'd1};
      req_b     = {32'd4, 32'd2};
      req_op    = {3'd0, 3'd4};
      req_is_fp = 2'b10;
      target    = n_accept + 6;
      start     = grant_log.size();
      req_valid = 2'b11;
      n = 0;
      #4;
      while (n_accept < target && n < 200) begin
         @(negedge clk);
         #4;
         n++;
      end
      check("rr_accepts", 72'(n_accept), 72'(target));
      @(negedge clk);
      req_valid = 2'b00;
      wait_done();
      for (int k = 0; k < 6; k++) begin
         if (start + k < grant_log.size()) begin
            check("rr_sequence", 72'(grant_log[start + k]), 72'(k % 2));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Sequencing controller that shares the single integer/FP ALU between two requesters (integer issue and FP issue paths). Arbitrates round-robin, registers the winner's operands and holds them stable on the ALU inputs for the op's latency. Captures the result and returns it through a valid/ready response channel. Sits between the issue stage and the ALU; the ALU itself is unchanged and purely combinational from this block's view.

## Interface

Reset is asynchronous and active-high. The block has a single clock.

Parameters:
- FP_LATENCY, default 3: cycles the operands are held before an FP result is sampled. Legal range is 1..15.
- INT_LATENCY, default 1: same, for integer ops. Legal range is 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  [1:0]  request valid per requester
- req_ready  out  [1:0]  request accepted this cycle
- req_a  in  [1:0][31:0]  operand A per requester
- req_b  in  [1:0][31:0]  operand B per requester
- req_op  in  [1:0][2:0]  op code per requester
- req_is_fp  in  [1:0]  FP flag per requester
- alu_a  out  32  to ALU operand A
- alu_b  out  32  to ALU operand B
- alu_op  out  3  to ALU op code
- alu_is_fp  out  1  to ALU FP flag
- alu_result  in  32  from ALU result
- rsp_valid  out  [1:0]  response valid, one-hot to the owning requester
- rsp_ready  in  [1:0]  response accepted per requester
- rsp_result  out  32  registered result
- busy  out  1  high whenever state is not IDLE

## Operation

- The FSM has three states: IDLE, EXEC and RESP.
- **IDLE:**
  - If any req_valid is set, the arbiter grants one requester.
  - req_ready[g] is asserted combinationally, and only for the granted g.
  - On that clock edge the block latches a, b, op and is_fp into the alu_* registers and stores the grant.
  - It loads the counter with INT_LATENCY-1 or FP_LATENCY-1, selected by req_is_fp[g], then moves to EXEC.
- **Arbitration:**
  - Round-robin, 2-way. The requester not granted last has priority.
  - After reset, priority is requester 0.
  - A single valid requester is always granted, regardless of priority.
- **EXEC:**
  - The counter decrements each cycle.
  - At count 0, alu_result is latched into rsp_result and the FSM moves to RESP.
- **RESP:**
  - rsp_valid[grant] is held high until rsp_ready[grant].
  - On the handshake edge the FSM returns to IDLE and rsp_valid clears.
  - rsp_ready of the non-owner is ignored.
- alu_* registers change only at request acceptance. They stay stable through EXEC, RESP and the following IDLE.
- Op codes pass through unmodified. An integer op 3'b111 completes normally, with the ALU returning 0.

Reset values (all asynchronous):
- State IDLE.
- req_ready=0, rsp_valid=0, busy=0.
- alu_a=alu_b=0, alu_op=0, alu_is_fp=0.
- rsp_result=0.
- RR priority = requester 0.

## Timing

- Request handshake at edge E0. busy is high from cycle E0+1.
- alu_result is sampled at edge E0+L, where L=INT_LATENCY or FP_LATENCY.
- rsp_valid is high from cycle E0+L. The latency from acceptance to response is L cycles.
- The response handshake at edge E1 returns the FSM to IDLE. A new accept can happen at edge E1+1 at the earliest.
- The minimum issue interval is L+2 cycles.
- No new request is accepted while busy. req_valid may stay asserted; the requester must hold its payload until req_ready.
- Both requesters valid in IDLE: exactly one req_ready bit is set, chosen by priority.
- Reset mid-EXEC or mid-RESP: the in-flight op is dropped and no response is issued. The FSM is in IDLE on the first cycle after reset deasserts.

## Structure

- Package alu_pkg:
  - alu_op_t enum: ADD=0, SUB, AND, OR, XOR, SLL, SRA.
  - arb_state_t enum: IDLE, EXEC, RESP.
  - Constant LAT_W=4.
- Sub-module rr_arb2 (combinational, with registered priority flop inside): inputs req[1:0] and an update strobe; output grant one-hot [1:0].

## Test plan

- **Single integer ADD:** req0 with a=5, b=7, op=000, is_fp=0 -> accepted at E0, alu_a/b = 5/7, rsp_valid[0] at E0+1 with rsp_result=12, rsp_valid[1] stays 0.
- **FP op, FP_LATENCY=3:** req1 with is_fp=1 -> rsp_valid[1] exactly 3 cycles after accept, and alu_* held constant the whole time.
- **Simultaneous requests after reset:** both valid -> req0 granted first. With both still valid, req1 is granted next, then req0, strictly alternating.
- **Response backpressure:** rsp_ready[0]=0 for 5 cycles -> rsp_valid[0] and rsp_result held, busy high, req1 not accepted. Raising rsp_ready[0] -> IDLE the next cycle.
- **Reset mid-EXEC:** assert rst during an FP op's second EXEC cycle -> all outputs 0 asynchronously and no rsp_valid. A post-reset request is granted to req0.
- **Op 3'b111 integer with a=32'hFFFF_FFFF:** rsp_result=0 after INT_LATENCY.
